// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int unsigned DEF_ADDR_W = 11;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned WAIT_W     = 4;
    localparam int unsigned CNT_W      = 16;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P0   = 2'd1,
        OWN_P1   = 2'd2
    } owner_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Two request ports plus the RAM macro pins, as seen by the arbiter.
interface dmem_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
);
    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_gnt;
    logic              p0_rvalid;
    logic [DATA_W-1:0] p0_rdata;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_gnt;
    logic              p1_rvalid;
    logic [DATA_W-1:0] p1_rdata;

    logic              ram_cen;
    logic              ram_wen;
    logic              ram_oen;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_d;
    logic [DATA_W-1:0] ram_q;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  ram_q,
        output p0_gnt, p0_rvalid, p0_rdata,
        output p1_gnt, p1_rvalid, p1_rdata,
        output ram_cen, ram_wen, ram_oen, ram_addr, ram_d
    );

    // Requesting masters together with the RAM macro that returns ram_q.
    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output ram_q,
        input  p0_gnt, p0_rvalid, p0_rdata,
        input  p1_gnt, p1_rvalid, p1_rdata,
        input  ram_cen, ram_wen, ram_oen, ram_addr, ram_d
    );

endinterface

// File: rtl/dmem_arb_wait_ctr.sv
// Counts consecutive denied port-1 cycles and flags when port 1 must override port 0.
module dmem_arb_wait_ctr
    import dmem_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic p1_req,
    input  logic p1_gnt,
    output logic override_c
);

    localparam logic [WAIT_W-1:0] WAIT_SAT = '1;
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (p1_req && !p1_gnt) begin
            if (wait_cnt != WAIT_SAT) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
        end else begin
            wait_cnt <= '0;
        end
    end

    assign override_c = (wait_cnt >= WAIT_LIM);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-ported data RAM between the execute stage (port 0, priority)
// and a secondary master (port 1, bounded wait), routing read data back to its issuer.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    dmem_arbiter_if.slave    bus,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    logic   override_c;
    logic   gnt0_c;
    logic   gnt1_c;
    owner_t rd_owner;
    owner_t rd_owner_nxt;

    dmem_arb_wait_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_ctr (
        .clk        (clk),
        .rst        (rst),
        .p1_req     (bus.p1_req),
        .p1_gnt     (gnt1_c),
        .override_c (override_c)
    );

    // Port 1 wins only when alone or once it has waited long enough.
    always_comb begin
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        if (!rst) begin
            if (bus.p1_req && (!bus.p0_req || override_c)) begin
                gnt1_c = 1'b1;
            end else if (bus.p0_req) begin
                gnt0_c = 1'b1;
            end
        end
    end

    assign bus.p0_gnt = gnt0_c;
    assign bus.p1_gnt = gnt1_c;

    // RAM pin drive; idle cycles park the address/data on port 0.
    always_comb begin
        bus.ram_cen  = 1'b1;
        bus.ram_wen  = 1'b1;
        bus.ram_addr = bus.p0_addr;
        bus.ram_d    = bus.p0_wdata;
        if (gnt1_c) begin
            bus.ram_cen  = 1'b0;
            bus.ram_wen  = ~bus.p1_we;
            bus.ram_addr = bus.p1_addr;
            bus.ram_d    = bus.p1_wdata;
        end else if (gnt0_c) begin
            bus.ram_cen  = 1'b0;
            bus.ram_wen  = ~bus.p0_we;
        end
    end

    assign bus.ram_oen = 1'b0;

    // Remember which port issued the read so the next cycle's ram_q goes back to it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_owner <= OWN_NONE;
        end else begin
            rd_owner <= rd_owner_nxt;
        end
    end

    always_comb begin
        rd_owner_nxt = OWN_NONE;
        if (gnt0_c && !bus.p0_we) begin
            rd_owner_nxt = OWN_P0;
        end else if (gnt1_c && !bus.p1_we) begin
            rd_owner_nxt = OWN_P1;
        end
    end

    assign bus.p0_rvalid = (rd_owner == OWN_P0);
    assign bus.p1_rvalid = (rd_owner == OWN_P1);
    assign bus.p0_rdata  = bus.ram_q;
    assign bus.p1_rdata  = bus.ram_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (bus.p0_req && bus.p1_req && (conflict_cnt != CNT_SAT)) begin
            conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: RAM macro model, behavioural reference with per-cycle
// compare, directed scenarios with literal expectations, then randomized traffic.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int unsigned AW = 11;
    localparam int unsigned DW = 32;
    localparam int unsigned MW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] conflict_cnt;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dmem_arbiter #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .MAX_WAIT (MW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // RAM macro: write or read on the edge, read data valid the following cycle.
    logic [DW-1:0] mem    [2**AW];
    logic [DW-1:0] shadow [2**AW];
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (!bus.ram_cen) begin
            if (!bus.ram_wen) mem[bus.ram_addr] <= bus.ram_d;
            else              bus.ram_q <= mem[bus.ram_addr];
        end
    end

    // Reference model state: what the spec says must happen, cycle by cycle.
    int            m_wait = 0;
    int            m_cnt = 0;
    int            pend_own = 0;
    logic [DW-1:0] pend_data = '0;
    logic          m_g0 = 1'b0;
    logic          m_g1 = 1'b0;

    always @(negedge clk) begin
        logic e0, e1;
        if (rst) begin
            m_wait = 0; m_cnt = 0; pend_own = 0; m_g0 = 1'b0; m_g1 = 1'b0;
            chk("rst_gnt0",    32'(bus.p0_gnt),    32'd0);
            chk("rst_gnt1",    32'(bus.p1_gnt),    32'd0);
            chk("rst_cen",     32'(bus.ram_cen),   32'd1);
            chk("rst_rvalid0", 32'(bus.p0_rvalid), 32'd0);
            chk("rst_rvalid1", 32'(bus.p1_rvalid), 32'd0);
            chk("rst_conflict", 32'(conflict_cnt), 32'd0);
        end else begin
            chk("rvalid0", 32'(bus.p0_rvalid), 32'(pend_own == 1));
            chk("rvalid1", 32'(bus.p1_rvalid), 32'(pend_own == 2));
            if (pend_own == 1) chk("rdata0", bus.p0_rdata, pend_data);
            if (pend_own == 2) chk("rdata1", bus.p1_rdata, pend_data);

            e1 = bus.p1_req && (!bus.p0_req || m_wait >= int'(MW));
            e0 = bus.p0_req && !e1;
            chk("gnt0", 32'(bus.p0_gnt), 32'(e0));
            chk("gnt1", 32'(bus.p1_gnt), 32'(e1));
            chk("cen",  32'(bus.ram_cen), 32'(!(e0 || e1)));
            chk("oen",  32'(bus.ram_oen), 32'd0);
            if (e1) begin
                chk("wen",  32'(bus.ram_wen),  32'(!bus.p1_we));
                chk("addr", 32'(bus.ram_addr), 32'(bus.p1_addr));
                chk("d",    bus.ram_d,         bus.p1_wdata);
            end else begin
                chk("wen",  32'(bus.ram_wen),  e0 ? 32'(!bus.p0_we) : 32'd1);
                chk("addr", 32'(bus.ram_addr), 32'(bus.p0_addr));
                chk("d",    bus.ram_d,         bus.p0_wdata);
            end
            chk("conflict", 32'(conflict_cnt), 32'(m_cnt));
            chk("wait_cnt", 32'(dut.u_wait_ctr.wait_cnt), 32'(m_wait));

            // Advance the model to the state after the coming edge.
            pend_own = 0;
            if (e0) begin
                if (bus.p0_we) shadow[bus.p0_addr] = bus.p0_wdata;
                else begin pend_own = 1; pend_data = shadow[bus.p0_addr]; end
            end
            if (e1) begin
                if (bus.p1_we) shadow[bus.p1_addr] = bus.p1_wdata;
                else begin pend_own = 2; pend_data = shadow[bus.p1_addr]; end
            end
            m_wait = (bus.p1_req && !e1) ? ((m_wait < 15) ? m_wait + 1 : 15) : 0;
            if (bus.p0_req && bus.p1_req && m_cnt < 65535) m_cnt++;
            m_g0 = e0;
            m_g1 = e1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        shadow[a] = d;
        step();
        pre_we = 1'b0;
    endtask

    task automatic set_p0(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.p0_req = req; bus.p0_we = we; bus.p0_addr = a; bus.p0_wdata = d;
    endtask

    task automatic set_p1(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.p1_req = req; bus.p1_we = we; bus.p1_addr = a; bus.p1_wdata = d;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        int r = int'($urandom % 32);
        return (r < 16) ? AW'(r) : AW'(2032 + r - 16);
    endfunction

    initial begin
        rst = 1'b1;
        set_p0(1'b0, 1'b0, '0, '0);
        set_p1(1'b0, 1'b0, '0, '0);
        step();
        for (int i = 0; i < 32; i++) begin
            logic [AW-1:0] a;
            a = (i < 16) ? AW'(i) : AW'(2032 + i - 16);
            preload(a, 32'hC0DE_0000 | 32'(a));
        end
        preload(11'h010, 32'hDEAD_BEEF);
        preload(11'h001, 32'h0000_000A);
        preload(11'h002, 32'h0000_000B);
        preload(11'h003, 32'h0000_000C);
        rst = 1'b0;

        // Single read from port 0.
        set_p0(1'b1, 1'b0, 11'h010, '0);
        @(negedge clk); chk("single_gnt0", 32'(bus.p0_gnt), 32'd1);
        step(); bus.p0_req = 1'b0;
        @(negedge clk);
        chk("single_rvalid0", 32'(bus.p0_rvalid), 32'd1);
        chk("single_rdata0",  bus.p0_rdata,       32'hDEAD_BEEF);
        chk("single_rvalid1", 32'(bus.p1_rvalid), 32'd0);
        step();

        // Port 1 write then read-back of the top address.
        set_p1(1'b1, 1'b1, 11'h7FF, 32'h1234_5678);
        @(negedge clk); chk("wr_gnt1", 32'(bus.p1_gnt), 32'd1);
        step(); bus.p1_we = 1'b0;
        @(negedge clk);
        chk("wr_no_rvalid", 32'({bus.p0_rvalid, bus.p1_rvalid}), 32'd0);
        step(); bus.p1_req = 1'b0;
        @(negedge clk);
        chk("rd_rvalid1", 32'(bus.p1_rvalid), 32'd1);
        chk("rd_rdata1",  bus.p1_rdata,       32'h1234_5678);
        step();

        // Starvation: port 1 denied MAX_WAIT cycles, granted on the next.
        set_p0(1'b1, 1'b0, 11'h000, '0);
        set_p1(1'b1, 1'b0, 11'h001, '0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("starve_gnt0", 32'(bus.p0_gnt), 32'(k < 4));
            chk("starve_gnt1", 32'(bus.p1_gnt), 32'(k == 4));
            step();
        end
        bus.p0_req = 1'b0; bus.p1_req = 1'b0;
        @(negedge clk);
        chk("starve_wait",     32'(dut.u_wait_ctr.wait_cnt), 32'd0);
        chk("starve_conflict", 32'(conflict_cnt),            32'd5);
        step();

        // Alternating reads P0, P1, P0.
        set_p0(1'b1, 1'b0, 11'h001, '0);
        step();
        bus.p0_req = 1'b0; set_p1(1'b1, 1'b0, 11'h002, '0);
        @(negedge clk);
        chk("alt_rvalid0_a", 32'(bus.p0_rvalid), 32'd1);
        chk("alt_rdata_a",   bus.p0_rdata,       32'h0000_000A);
        step();
        bus.p1_req = 1'b0; set_p0(1'b1, 1'b0, 11'h003, '0);
        @(negedge clk);
        chk("alt_rvalid1_b", 32'(bus.p1_rvalid), 32'd1);
        chk("alt_rdata_b",   bus.p1_rdata,       32'h0000_000B);
        step();
        bus.p0_req = 1'b0;
        @(negedge clk);
        chk("alt_rvalid0_c", 32'(bus.p0_rvalid), 32'd1);
        chk("alt_rdata_c",   bus.p0_rdata,       32'h0000_000C);
        step();

        // Reset lands in the cycle after a read grant.
        set_p0(1'b1, 1'b0, 11'h000, '0);
        set_p1(1'b1, 1'b0, 11'h002, '0);
        step();
        rst = 1'b1; bus.p0_req = 1'b0; bus.p1_req = 1'b0;
        @(negedge clk);
        chk("midrst_rvalid0", 32'(bus.p0_rvalid), 32'd0);
        chk("midrst_cen",     32'(bus.ram_cen),   32'd1);
        step(); rst = 1'b0;
        @(negedge clk);
        chk("midrst_conflict", 32'(conflict_cnt),            32'd0);
        chk("midrst_wait",     32'(dut.u_wait_ctr.wait_cnt), 32'd0);
        step();

        // One conflicting write pair, then ten idle cycles.
        set_p0(1'b1, 1'b1, 11'h004, 32'h4444_0000);
        set_p1(1'b1, 1'b1, 11'h005, 32'h5555_0000);
        step(); bus.p0_req = 1'b0;
        step(); bus.p1_req = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("idle_cen",      32'(bus.ram_cen), 32'd1);
            chk("idle_wen",      32'(bus.ram_wen), 32'd1);
            chk("idle_gnt",      32'({bus.p0_gnt, bus.p1_gnt}), 32'd0);
            chk("idle_rvalid",   32'({bus.p0_rvalid, bus.p1_rvalid}), 32'd0);
            chk("idle_conflict", 32'(conflict_cnt), 32'd1);
            step();
        end

        // Randomized traffic; requests are held until granted or occasionally dropped.
        for (int n = 0; n < 4000; n++) begin
            rst = (($urandom % 500) == 0);
            if (!bus.p0_req || m_g0) begin
                set_p0(($urandom % 4) != 0, ($urandom % 3) == 0, rand_addr(), $urandom);
            end else if (($urandom % 16) == 0) begin
                bus.p0_req = 1'b0;
            end
            if (!bus.p1_req || m_g1) begin
                set_p1(($urandom % 2) != 0, ($urandom % 3) == 0, rand_addr(), $urandom);
            end else if (($urandom % 16) == 0) begin
                bus.p1_req = 1'b0;
            end
            step();
        end
        rst = 1'b0;
        bus.p0_req = 1'b0; bus.p1_req = 1'b0;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-ported 2Kx32 data memory between the execute stage (port 0, load/store) and a secondary master (port 1, debug/DMA loader). It sits between the execute stage and the RAM macro, driving the macro's active-low CEN/WEN/OEN pins. Port 0 has priority. A wait counter guarantees port 1 a grant within a bounded number of cycles. The RAM's one-cycle read latency is tracked so each read response returns to the port that issued it.

## Interface
- ADDR_W, 11, RAM word-address width
- DATA_W, 32, data width
- MAX_WAIT, 4, consecutive denied cycles after which port 1 overrides port 0 (range 1..15)
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- p0_req / p1_req  in  1  access request; held until granted
- p0_we / p1_we  in  1  1 = write, 0 = read
- p0_addr / p1_addr  in  ADDR_W  word address
- p0_wdata / p1_wdata  in  DATA_W  write data
- p0_gnt / p1_gnt  out  1  combinational grant; the access occurs at the next rising edge
- p0_rvalid / p1_rvalid  out  1  registered one-cycle pulse; read data is valid this cycle
- p0_rdata / p1_rdata  out  DATA_W  both ports are driven directly from ram_q
- ram_cen  out  1  RAM chip enable, active-low
- ram_wen  out  1  RAM write enable, active-low
- ram_oen  out  1  RAM output enable, tied 0
- ram_addr  out  ADDR_W  RAM address
- ram_d  out  DATA_W  RAM write data
- ram_q  in  DATA_W  RAM read data, valid the cycle after a read edge
- conflict_cnt  out  16  saturating count of cycles in which both ports requested

## Operation
- Grant logic is combinational. At most one gnt is high per cycle.
  - Only one port requesting: that port is granted.
  - Both requesting: port 0 wins unless wait_cnt >= MAX_WAIT, in which case port 1 wins.
  - rst high: both gnt are 0.
- RAM drive:
  - Granted port: ram_cen=0, ram_wen=~we, and that port's addr and wdata are routed to the RAM.
  - No grant: ram_cen=1, ram_wen=1, ram_addr and ram_d hold port 0's values.
- wait_cnt (4 bits):
  - Increments, saturating at 15, each cycle with p1_req=1 and p1_gnt=0.
  - Clears on any cycle with p1_gnt=1, or when p1_req=0.
- rd_owner is one of NONE, P0, P1, registered each edge.
  - Becomes P0 or P1 on an edge where that port holds a read grant (gnt & ~we); otherwise NONE.
  - pN_rvalid = (rd_owner==PN).
- Writes produce no rvalid.
- Back-to-back reads from either or alternating ports are supported at one per cycle. Each rvalid pairs with the grant one cycle earlier.
- A read of an address written in the previous cycle returns the new data; the RAM guarantees write-then-read ordering.
- conflict_cnt increments, saturating at 16'hFFFF, on each edge where p0_req and p1_req are both 1.
- A master deasserting req without a grant is legal: the request is dropped and no access occurs.

## Timing
- Reset values: wait_cnt=0, rd_owner=NONE, p0_rvalid=p1_rvalid=0, conflict_cnt=0. Both gnt are 0 and ram_cen=1 while rst is high.
- Reset asserted mid-read: the pending rvalid is cleared asynchronously and is never delivered.
- Grant-to-access latency: 0 cycles, at the same edge. Read latency: the rvalid pulse appears in the cycle after the grant edge.
- Worst-case port 1 wait under continuous port 0 traffic: MAX_WAIT denied cycles, then granted on cycle MAX_WAIT+1.
- Port 0 starvation is bounded to 1 cycle per MAX_WAIT+1 cycles.

## Structure
- Package dmem_arb_pkg holds:
  - owner_t enum {OWN_NONE, OWN_P0, OWN_P1}
  - the default ADDR_W and DATA_W constants
  - the WAIT_W=4 constant
- One sub-module, dmem_arb_wait_ctr: the saturating wait counter plus the override compare. It takes p1_req, p1_gnt and MAX_WAIT and produces the override flag.
- All other logic (grant mux, rd_owner register, conflict counter) lives in dmem_arbiter.

## Test plan
- Single read: p0 reads addr 0x010 preloaded with 0xDEADBEEF. Required: p0_gnt in the same cycle, p0_rvalid=1 with p0_rdata=0xDEADBEEF one cycle later, p1_rvalid stays 0.
- Write then read: p1 writes 0x12345678 to addr 0x7FF, then p1 reads 0x7FF on the next cycle. Required: no rvalid after the write; p1_rvalid with 0x12345678 two cycles after the write grant.
- Starvation: p0 reads every cycle and p1 holds a read request with MAX_WAIT=4. Required: p1 denied for 4 cycles and granted on the 5th; p0_gnt=0 in that cycle; wait_cnt=0 afterwards; conflict_cnt=5.
- Alternating reads: grants alternate P0, P1, P0 at addresses 1, 2, 3 holding 0xA, 0xB, 0xC. Required: rvalid pulses p0, p1, p0 on consecutive cycles carrying 0xA, 0xB, 0xC.
- Reset mid-read: rst asserted in the cycle after a p0 read grant. Required: p0_rvalid=0 immediately, ram_cen=1, and conflict_cnt and wait_cnt read 0 after release.
- Idle: no requests for 10 cycles. Required: ram_cen=1, ram_wen=1, no gnt, no rvalid, conflict_cnt unchanged.
